// File: rtl/output_shift_reg.sv
// Output shift register for one PIO state machine: OUT shifts, PULL loads,
// autopull refill from the tx FIFO, threshold tracking and stall back-pressure.
module output_shift_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              shift_right,
    input  logic              autopull_en,
    input  logic [4:0]        pull_thresh,
    input  logic [DATA_W-1:0] fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_pop,
    input  logic [DATA_W-1:0] x_in,
    input  logic              out_req,
    input  logic [4:0]        out_count,
    input  logic              pull_req,
    input  logic              pull_block,
    input  logic              pull_iffull,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              stall,
    output logic              osr_empty,
    output logic [5:0]        shift_count
);

    typedef enum logic [1:0] {IDLE, OUT_WAIT, PULL_WAIT} state_t;

    state_t            state, nxt;
    logic [DATA_W-1:0] osr;
    logic [5:0]        thr, n;
    logic [6:0]        sum;
    logic [5:0]        count_sat;
    logic [DATA_W-1:0] mask, shr, shl, left_out;
    logic              need_refill, pop, load_fifo, load_x, do_out, stall_c;

    always_comb begin
        thr         = (pull_thresh == 5'd0) ? 6'd32 : {1'b0, pull_thresh};
        n           = (out_count == 5'd0) ? 6'd32 : {1'b0, out_count};
        osr_empty   = (shift_count >= thr);
        need_refill = autopull_en && osr_empty;

        pop       = 1'b0;
        load_fifo = 1'b0;
        load_x    = 1'b0;
        do_out    = 1'b0;
        stall_c   = 1'b0;
        nxt       = IDLE;

        // PULL wins over OUT; an iffull PULL below threshold is a completed no-op
        if (pull_req) begin
            if (pull_iffull && !osr_empty) begin
                pop = 1'b0;
            end else if (!fifo_empty) begin
                pop       = 1'b1;
                load_fifo = 1'b1;
            end else if (!pull_block) begin
                load_x = 1'b1;
            end else begin
                stall_c = 1'b1;
                nxt     = PULL_WAIT;
            end
        end else if (out_req) begin
            if (need_refill) begin
                stall_c = 1'b1;
                nxt     = OUT_WAIT;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    load_fifo = 1'b1;
                end
            end else begin
                do_out = 1'b1;
            end
        end else if (state == IDLE && need_refill && !fifo_empty) begin
            pop       = 1'b1;
            load_fifo = 1'b1;
        end

        // Reset must silence the strobes immediately, not at the next edge
        fifo_pop = pop && rst;
        stall    = stall_c && rst;

        mask      = (n == 6'd32) ? '1 : ((DATA_W'(1) << n) - DATA_W'(1));
        shr       = osr >> n;
        shl       = osr << n;
        left_out  = osr >> (6'd32 - n);
        sum       = {1'b0, shift_count} + {1'b0, n};
        count_sat = (sum > 7'd32) ? 6'd32 : sum[5:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            osr         <= '0;
            shift_count <= 6'd32;
            out_valid   <= 1'b0;
            out_data    <= '0;
        end else begin
            state     <= nxt;
            out_valid <= do_out;
            if (load_fifo) begin
                osr         <= fifo_data;
                shift_count <= 6'd0;
            end else if (load_x) begin
                osr         <= x_in;
                shift_count <= 6'd0;
            end else if (do_out) begin
                osr         <= shift_right ? shr : shl;
                out_data    <= shift_right ? (osr & mask) : left_out;
                shift_count <= count_sat;
            end
        end
    end

endmodule

// File: tb/tb_output_shift_reg.sv
// Directed bench for output_shift_reg: queue-based tx FIFO model plus an
// out_data scoreboard filled when OUTs are issued and drained on out_valid.
module tb_output_shift_reg;

    logic        clk = 1'b0;
    logic        rst;
    logic        shift_right, autopull_en;
    logic [4:0]  pull_thresh, out_count;
    logic [31:0] fifo_data, x_in, out_data;
    logic        fifo_empty, fifo_pop;
    logic        out_req, pull_req, pull_block, pull_iffull;
    logic        out_valid, stall, osr_empty;
    logic [5:0]  shift_count;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    int p0;
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    output_shift_reg dut (
        .clk(clk), .rst(rst), .shift_right(shift_right), .autopull_en(autopull_en),
        .pull_thresh(pull_thresh), .fifo_data(fifo_data), .fifo_empty(fifo_empty),
        .fifo_pop(fifo_pop), .x_in(x_in), .out_req(out_req), .out_count(out_count),
        .pull_req(pull_req), .pull_block(pull_block), .pull_iffull(pull_iffull),
        .out_valid(out_valid), .out_data(out_data), .stall(stall),
        .osr_empty(osr_empty), .shift_count(shift_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic fifo_sync();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = fifo_empty ? 32'h0 : fifo_q[0];
    endtask

    task automatic push(input logic [31:0] w);
        fifo_q.push_back(w);
        fifo_sync();
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // FIFO model: head advances just after the edge that consumed it
    always @(posedge clk) begin
        if (fifo_pop === 1'b1) begin
            pops++;
            chk("pop_when_empty", {31'b0, fifo_empty}, 32'd0);
            #1;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
            fifo_sync();
        end
    end

    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                assert (exp_q.size() != 0) else begin
                    errors++;
                    $error("FAIL out_unexpected observed=%h expected=none", out_data);
                end
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b0; shift_right = 1'b0; autopull_en = 1'b0; pull_thresh = 5'd0;
        out_count = 5'd0; x_in = 32'h0; out_req = 1'b0; pull_req = 1'b0;
        pull_block = 1'b0; pull_iffull = 1'b0;
        fifo_sync();

        tick(); #1;
        chk("rst_stall", {31'b0, stall}, 32'd0);
        chk("rst_pop", {31'b0, fifo_pop}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_shift_count", {26'b0, shift_count}, 32'd32);
        chk("rst_osr_empty", {31'b0, osr_empty}, 32'd1);
        tick(); rst = 1'b1;

        // right shifts of 0xDEADBEEF
        tick(); shift_right = 1'b1; push(32'hDEADBEEF); pull_req = 1'b1; #1;
        chk("pull_stall", {31'b0, stall}, 32'd0);
        chk("pull_pop", {31'b0, fifo_pop}, 32'd1);
        tick(); pull_req = 1'b0; #1;
        chk("pull_count", {26'b0, shift_count}, 32'd0);
        out_req = 1'b1; out_count = 5'd8;
        exp_q.push_back(32'hEF); #1;
        chk("out_stall", {31'b0, stall}, 32'd0);
        tick(); exp_q.push_back(32'hBE);
        tick(); exp_q.push_back(32'hAD);
        tick(); out_req = 1'b0; #1;
        chk("right_count", {26'b0, shift_count}, 32'd24);

        // left shift by 32
        shift_right = 1'b0; push(32'h80000001); pull_req = 1'b1;
        tick(); pull_req = 1'b0; out_req = 1'b1; out_count = 5'd0;
        exp_q.push_back(32'h80000001);
        tick(); out_req = 1'b0; #1;
        chk("left32_count", {26'b0, shift_count}, 32'd32);
        chk("left32_empty", {31'b0, osr_empty}, 32'd1);
        out_req = 1'b1; exp_q.push_back(32'h0);
        tick(); out_req = 1'b0;

        // autopull with threshold 16
        autopull_en = 1'b1; pull_thresh = 5'd16; shift_right = 1'b1;
        tick(); push(32'h11112222); #1;
        chk("refill_pop", {31'b0, fifo_pop}, 32'd1);
        tick(); #1;
        chk("refill_count", {26'b0, shift_count}, 32'd0);
        out_req = 1'b1; out_count = 5'd16; exp_q.push_back(32'h2222);
        tick(); out_req = 1'b0; #1;
        chk("ap_count16", {26'b0, shift_count}, 32'd16);
        p0 = pops; out_count = 5'd4; out_req = 1'b1; exp_q.push_back(32'hD); #1;
        chk("ap_stall0", {31'b0, stall}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            chk("ap_stall_held", {31'b0, stall}, 32'd1);
        end
        chk("ap_no_pop", pops - p0, 32'd0);
        push(32'h0000ABCD); #1;
        chk("ap_pop", {31'b0, fifo_pop}, 32'd1);
        chk("ap_stall_refill", {31'b0, stall}, 32'd1);
        tick(); #1;
        chk("ap_exec", {31'b0, stall}, 32'd0);
        tick(); out_req = 1'b0; #1;
        chk("ap_count4", {26'b0, shift_count}, 32'd4);
        chk("ap_one_pop", pops - p0, 32'd1);

        // reset while stalled in OUT_WAIT
        out_count = 5'd12; out_req = 1'b1; exp_q.push_back(32'hABC);
        tick(); out_req = 1'b0; #1;
        chk("pre_rst_count", {26'b0, shift_count}, 32'd16);
        out_count = 5'd4; out_req = 1'b1;
        tick(); #1;
        chk("pre_rst_stall", {31'b0, stall}, 32'd1);
        rst = 1'b0; push(32'h99); #1;
        chk("rst_mid_stall", {31'b0, stall}, 32'd0);
        chk("rst_mid_pop", {31'b0, fifo_pop}, 32'd0);
        chk("rst_mid_count", {26'b0, shift_count}, 32'd32);
        out_req = 1'b0; autopull_en = 1'b0; fifo_q.delete(); fifo_sync();
        tick(); rst = 1'b1;
        tick(); out_req = 1'b1; out_count = 5'd0; exp_q.push_back(32'h0);
        tick(); out_req = 1'b0;

        // PULL on empty FIFO, non-blocking then blocking
        x_in = 32'h55; pull_block = 1'b0; pull_req = 1'b1; p0 = pops; #1;
        chk("pullx_stall", {31'b0, stall}, 32'd0);
        chk("pullx_pop", {31'b0, fifo_pop}, 32'd0);
        tick(); pull_req = 1'b0; out_req = 1'b1; exp_q.push_back(32'h55);
        tick(); out_req = 1'b0;
        pull_block = 1'b1; pull_req = 1'b1; p0 = pops; #1;
        chk("pullb_stall0", {31'b0, stall}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            tick(); #1;
            chk("pullb_stall_held", {31'b0, stall}, 32'd1);
        end
        push(32'h12); #1;
        chk("pullb_release", {31'b0, stall}, 32'd0);
        chk("pullb_pop", {31'b0, fifo_pop}, 32'd1);
        tick(); pull_req = 1'b0; pull_block = 1'b0; #1;
        chk("pullb_one_pop", pops - p0, 32'd1);
        chk("pullb_count", {26'b0, shift_count}, 32'd0);
        out_req = 1'b1; exp_q.push_back(32'h12);
        tick(); out_req = 1'b0;

        // IFFULL below threshold is a no-op
        pull_thresh = 5'd8; push(32'hCAFEF00D); pull_req = 1'b1;
        tick(); pull_req = 1'b0; out_req = 1'b1; out_count = 5'd4; exp_q.push_back(32'hD);
        tick(); out_req = 1'b0; #1;
        chk("iff_count", {26'b0, shift_count}, 32'd4);
        push(32'h77); pull_req = 1'b1; pull_iffull = 1'b1; p0 = pops; #1;
        chk("iff_stall", {31'b0, stall}, 32'd0);
        chk("iff_pop", {31'b0, fifo_pop}, 32'd0);
        tick(); pull_req = 1'b0; pull_iffull = 1'b0; #1;
        chk("iff_count_kept", {26'b0, shift_count}, 32'd4);
        chk("iff_no_pop", pops - p0, 32'd0);
        out_req = 1'b1; out_count = 5'd0; exp_q.push_back(32'h0CAFEF00);
        tick(); out_req = 1'b0;

        repeat (3) tick();
        chk("scoreboard_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
